sw_alloc_rr: RTL and testbench
==============================

# sw_alloc_rr

Parametrised wormhole switch allocator for the mesh router: arbitrates NPORT input channels onto NPORT output ports with per-output round-robin fairness, packet-level output locking, and per-output-VC credit counting. Sits between the input channels and the crossbar, replacing the fixed 5-port, request/grant-only allocation with a generalised block that also owns downstream buffer credits.

## Interface
Parameters:
- NPORT, 5, number of input and output ports
- NVC, 2, virtual channels per output port
- CREDITS, 4, downstream buffer depth per output VC (reset credit value, saturation limit)
- VCW, $clog2(NVC) (min 1), VC index width
- CW, $clog2(CREDITS+1), credit counter width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_  input  1  asynchronous reset, active-high
- req  input  NPORT*NPORT  row i (bits i*NPORT+:NPORT) = output one-hot requested by input i
- req_vc  input  NPORT*VCW  target output VC of input i's head flit
- req_tail  input  NPORT  flit presented by input i is a tail (single-flit packet: head and tail)
- credit_in  input  NPORT*NVC  one-cycle pulse: one credit returned for output j, VC v (bit j*NVC+v)
- grt  output  NPORT*NPORT  row i = one-hot output granted to input i this cycle
- grt_vc  output  NPORT*VCW  VC used by input i's granted flit
- vc_rdy  output  NPORT*NVC  credit count of output j VC v is nonzero
- out_lck  output  NPORT  output j locked to a packet in progress
- err  output  1  sticky credit-overflow flag

## Operation
- Per output j state: lock bit, owner (input index), locked VC, RR pointer ptr[j], NVC credit counters.
- Multi-hot req row: only lowest set bit is honoured.
- Unlocked output j: eligible inputs = requesting j whose req_vc has credit > 0; grant the first eligible at or after ptr[j] (wrapping modulo NPORT).
- Locked output j: only owner eligible; its flit uses the locked VC (req_vc ignored); granted only if that VC has credit > 0.
- On grant of non-tail flit to unlocked output: lock set, owner/VC captured.
- On grant of tail flit: lock cleared; ptr[j] = granted input + 1 (wraps to 0 after NPORT-1). Pointer never moves on non-tail grants.
- Each input receives at most one grant per cycle (one output requested).
- Credit counter: grant -> −1; credit_in -> +1; both same cycle -> unchanged. Counter never decremented below 0 (grant impossible at 0).
- credit_in while counter == CREDITS (and no simultaneous grant): counter holds CREDITS, err set; err cleared only by reset.
- Reset mid-packet: all locks dropped, credits restored; upstream must discard partial packets.

## Timing
- grt, grt_vc combinational from req/req_vc/req_tail and current state: zero-cycle grant latency.
- Lock, ptr, credit updates visible the cycle after the grant edge.
- Credit returned in cycle t usable for grant in cycle t+1.
- vc_rdy, out_lck, err are registered-state decodes.
- During and after reset: grt = 0, grt_vc = 0, out_lck = 0, vc_rdy = all ones, err = 0, ptr = 0, counters = CREDITS.
- grt forced to 0 while rst_ asserted.

## Test plan
- Reset, then inputs 0,1,2 all request output 4 VC0 single-flit, held 3 cycles -> grants 0, then 1, then 2; ptr[4] = 3 after.
- Input 1 sends 3-flit packet to output 2 VC1, input 3 requests output 2 in between -> input 3 blocked until cycle after input 1 tail; out_lck[2] high for 2 cycles.
- NVC=2, CREDITS=4: 4 single-flit grants on output 0 VC0 with no credit_in -> 5th request stalls, vc_rdy[0] = 0; one credit_in pulse -> grant next cycle.
- Grant and credit_in on same output/VC same cycle at count 2 -> count stays 2.
- credit_in on full counter -> err = 1 next cycle, counter stays 4; remains 1 until rst_.
- Assert rst_ mid-packet with output 3 locked -> out_lck[3] = 0, grt = 0 immediately; after release, new head from another input granted.

Source files
------------

// File: rtl/sw_alloc_rr.sv
// sw_alloc_rr -- wormhole switch allocator for the mesh router.
//
// Arbitrates NPORT input channels onto NPORT output ports. Each output port
// keeps a round-robin pointer, a packet lock (owner input + VC), and one
// downstream credit counter per VC. Grants are combinational from the
// current requests and registered state, so grant latency is zero cycles.
//
// Ports:
//   clk        clock, rising edge
//   rst_       asynchronous reset, active high
//   req        row i = one-hot output requested by input i (lowest bit wins)
//   req_vc     target output VC of input i's head flit
//   req_tail   input i's flit is a tail (head+tail for single-flit packets)
//   credit_in  one-cycle credit return pulse, bit j*NVC+v
//   grt        row i = one-hot output granted to input i
//   grt_vc     VC used by input i's granted flit
//   vc_rdy     credit count of output j VC v is nonzero
//   out_lck    output j locked to a packet in progress
//   err        sticky credit-overflow flag

// Per-output arbiter: lock/owner state, RR pointer and VC credit counters.
module sw_alloc_out #(
  parameter int NPORT   = 5,
  parameter int NVC     = 2,
  parameter int CREDITS = 4,
  parameter int VCW     = 1,
  parameter int CW      = 3,
  parameter int PW      = 3
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic [NPORT-1:0]          rq_i,     // inputs requesting this output
  input  logic [NPORT-1:0][VCW-1:0] rvc_i,
  input  logic [NPORT-1:0]          rtail_i,
  input  logic [NVC-1:0]            cin_i,
  output logic [NPORT-1:0]          gnt_o,
  output logic [VCW-1:0]            gvc_o,
  output logic                      lck_o,
  output logic [NVC-1:0]            rdy_o,
  output logic                      ovf_o
);
  logic [NVC-1:0][CW-1:0] cnt_q, cnt_d;
  logic                   lck_q, lck_d;
  logic [PW-1:0]          own_q, own_d;
  logic [VCW-1:0]         lvc_q, lvc_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic                   ovf_q, ovf_d;

  logic [(1<<VCW)-1:0]    rdy_x;  // rdy padded so any VC code indexes safely
  logic [NPORT-1:0]       elig;
  logic                   found;
  logic [PW-1:0]          gidx;
  logic [VCW-1:0]         gvc;
  logic                   gtail;

  always_comb begin
    for (int v = 0; v < NVC; v++) rdy_o[v] = (cnt_q[v] != '0);
  end

  always_comb begin
    rdy_x = '0;
    rdy_x[NVC-1:0] = rdy_o;
  end

  // Locked: only the owner may continue, on the locked VC.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (lck_q) elig[i] = rq_i[i] && (own_q == PW'(i)) && rdy_x[lvc_q];
      else       elig[i] = rq_i[i] && rdy_x[rvc_i[i]];
    end
  end

  // First eligible input at or after ptr_q, wrapping.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NPORT; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NPORT) idx = idx - NPORT;
      if (!found && elig[idx]) begin
        found = 1'b1;
        gidx  = PW'(idx);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    gvc   = '0;
    gtail = 1'b0;
    if (found && !rst_i) begin
      gnt_o[gidx] = 1'b1;
      gvc         = lck_q ? lvc_q : rvc_i[gidx];
      gtail       = rtail_i[gidx];
    end
  end

  assign gvc_o = gvc;
  assign lck_o = lck_q;
  assign ovf_o = ovf_q;

  always_comb begin
    lck_d = lck_q;
    own_d = own_q;
    lvc_d = lvc_q;
    ptr_d = ptr_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (found) begin
      if (gtail) begin
        lck_d = 1'b0;
        ptr_d = (gidx == PW'(NPORT-1)) ? '0 : gidx + PW'(1);
      end else if (!lck_q) begin
        lck_d = 1'b1;
        own_d = gidx;
        lvc_d = gvc;
      end
    end
    for (int v = 0; v < NVC; v++) begin
      logic dec;
      dec = found && (gvc == VCW'(v));
      if (dec && !cin_i[v]) begin
        cnt_d[v] = cnt_q[v] - CW'(1);
      end else if (cin_i[v] && !dec) begin
        if (cnt_q[v] == CW'(CREDITS)) ovf_d = 1'b1;
        else                          cnt_d[v] = cnt_q[v] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {NVC{CW'(CREDITS)}};
      lck_q <= 1'b0;
      own_q <= '0;
      lvc_q <= '0;
      ptr_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lck_q <= lck_d;
      own_q <= own_d;
      lvc_q <= lvc_d;
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

module sw_alloc_rr #(
  parameter int NPORT   = 5,
  parameter int NVC     = 2,
  parameter int CREDITS = 4,
  parameter int VCW     = (NVC > 1) ? $clog2(NVC) : 1,
  parameter int CW      = $clog2(CREDITS+1)
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [NPORT*NPORT-1:0] req,
  input  logic [NPORT*VCW-1:0]   req_vc,
  input  logic [NPORT-1:0]       req_tail,
  input  logic [NPORT*NVC-1:0]   credit_in,
  output logic [NPORT*NPORT-1:0] grt,
  output logic [NPORT*VCW-1:0]   grt_vc,
  output logic [NPORT*NVC-1:0]   vc_rdy,
  output logic [NPORT-1:0]       out_lck,
  output logic                   err
);
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [NPORT-1:0][NPORT-1:0] req_a, req_lo, col, gcol, grt_a;
  logic [NPORT-1:0][VCW-1:0]   rvc_a, gvc_a, gvc_o;
  logic [NPORT-1:0][NVC-1:0]   cin_a, rdy_a;
  logic [NPORT-1:0]            ovf;

  assign req_a = req;
  assign rvc_a = req_vc;
  assign cin_a = credit_in;

  // Multi-hot rows: isolate the lowest set bit.
  always_comb begin
    for (int i = 0; i < NPORT; i++) req_lo[i] = req_a[i] & (~req_a[i] + 1'b1);
  end

  // Transpose row-per-input to column-per-output and back.
  always_comb begin
    for (int i = 0; i < NPORT; i++)
      for (int j = 0; j < NPORT; j++) begin
        col[j][i]   = req_lo[i][j];
        grt_a[i][j] = gcol[j][i];
      end
  end

  // An input requests at most one output, so OR-reducing the VCs is exact.
  always_comb begin
    gvc_a = '0;
    for (int i = 0; i < NPORT; i++)
      for (int j = 0; j < NPORT; j++)
        if (gcol[j][i]) gvc_a[i] = gvc_a[i] | gvc_o[j];
  end

  genvar j;
  generate
    for (j = 0; j < NPORT; j++) begin : g_out
      sw_alloc_out #(
        .NPORT(NPORT), .NVC(NVC), .CREDITS(CREDITS),
        .VCW(VCW), .CW(CW), .PW(PW)
      ) u_out (
        .clk    (clk),
        .rst_i  (rst_),
        .rq_i   (col[j]),
        .rvc_i  (rvc_a),
        .rtail_i(req_tail),
        .cin_i  (cin_a[j]),
        .gnt_o  (gcol[j]),
        .gvc_o  (gvc_o[j]),
        .lck_o  (out_lck[j]),
        .rdy_o  (rdy_a[j]),
        .ovf_o  (ovf[j])
      );
    end
  endgenerate

  assign grt    = grt_a;
  assign grt_vc = gvc_a;
  assign vc_rdy = rdy_a;
  assign err    = |ovf;
endmodule

// File: tb/tb_sw_alloc_rr.sv
module tb_sw_alloc_rr;
  logic        clk = 1'b0;
  logic        rst_;
  logic [24:0] req;
  logic [4:0]  req_vc;
  logic [4:0]  req_tail;
  logic [9:0]  credit_in;
  logic [24:0] grt;
  logic [4:0]  grt_vc;
  logic [9:0]  vc_rdy;
  logic [4:0]  out_lck;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  sw_alloc_rr dut (
    .clk(clk), .rst_(rst_), .req(req), .req_vc(req_vc), .req_tail(req_tail),
    .credit_in(credit_in), .grt(grt), .grt_vc(grt_vc), .vc_rdy(vc_rdy),
    .out_lck(out_lck), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] rb(input int i, input int j);
    logic [24:0] r;
    r = '0;
    r[i*5+j] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b1; req = '0; req_vc = '0; req_tail = '0; credit_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b0;
  endtask

  task automatic test_reset();
    rst_ = 1'b1; req = rb(0,0) | rb(1,2); req_vc = '0; req_tail = 5'h1f; credit_in = '0;
    @(posedge clk); #2;
    n_cmp++; if (grt !== '0)      begin n_bad++; $display("FAIL rst_grt got=%h exp=0", grt); end
    n_cmp++; if (grt_vc !== '0)   begin n_bad++; $display("FAIL rst_grt_vc got=%h exp=0", grt_vc); end
    n_cmp++; if (out_lck !== '0)  begin n_bad++; $display("FAIL rst_lck got=%h exp=0", out_lck); end
    n_cmp++; if (vc_rdy !== 10'h3ff) begin n_bad++; $display("FAIL rst_rdy got=%h exp=3ff", vc_rdy); end
    n_cmp++; if (err !== 1'b0)    begin n_bad++; $display("FAIL rst_err got=%b exp=0", err); end
    req = '0; rst_ = 1'b0;
  endtask

  task automatic test_rr();
    do_reset();
    req = rb(0,4) | rb(1,4) | rb(2,4); req_vc = '0; req_tail = 5'b00111;
    #1;
    n_cmp++; if (grt !== rb(0,4)) begin n_bad++; $display("FAIL rr_c0 got=%h exp=%h", grt, rb(0,4)); end
    tick(); #1;
    n_cmp++; if (grt !== rb(1,4)) begin n_bad++; $display("FAIL rr_c1 got=%h exp=%h", grt, rb(1,4)); end
    tick(); #1;
    n_cmp++; if (grt !== rb(2,4)) begin n_bad++; $display("FAIL rr_c2 got=%h exp=%h", grt, rb(2,4)); end
    tick();
    // pointer now 3: input 4 wins over input 0
    req = rb(0,4) | rb(4,4); req_tail = 5'b10001; #1;
    n_cmp++; if (grt !== rb(4,4)) begin n_bad++; $display("FAIL rr_ptr got=%h exp=%h", grt, rb(4,4)); end
    n_cmp++; if (grt_vc !== 5'b0) begin n_bad++; $display("FAIL rr_vc got=%h exp=0", grt_vc); end
    tick(); req = '0; #1;
    n_cmp++; if (vc_rdy[8] !== 1'b0) begin n_bad++; $display("FAIL rr_rdy got=%b exp=0", vc_rdy[8]); end
  endtask

  task automatic test_lock();
    do_reset();
    req = rb(1,2) | rb(3,2); req_vc = 5'b00010; req_tail = 5'b01000; #1;
    n_cmp++; if (grt !== rb(1,2)) begin n_bad++; $display("FAIL lk_head got=%h exp=%h", grt, rb(1,2)); end
    n_cmp++; if (grt_vc !== 5'b00010) begin n_bad++; $display("FAIL lk_head_vc got=%h exp=02", grt_vc); end
    tick(); req_vc = 5'b00000; #1;
    n_cmp++; if (grt !== rb(1,2)) begin n_bad++; $display("FAIL lk_body got=%h exp=%h", grt, rb(1,2)); end
    n_cmp++; if (grt_vc !== 5'b00010) begin n_bad++; $display("FAIL lk_body_vc got=%h exp=02", grt_vc); end
    n_cmp++; if (out_lck !== 5'b00100) begin n_bad++; $display("FAIL lk_lck1 got=%h exp=04", out_lck); end
    tick(); req_tail = 5'b01010; #1;
    n_cmp++; if (grt !== rb(1,2)) begin n_bad++; $display("FAIL lk_tail got=%h exp=%h", grt, rb(1,2)); end
    n_cmp++; if (out_lck !== 5'b00100) begin n_bad++; $display("FAIL lk_lck2 got=%h exp=04", out_lck); end
    tick(); req = rb(3,2); req_tail = 5'b01000; #1;
    n_cmp++; if (grt !== rb(3,2)) begin n_bad++; $display("FAIL lk_next got=%h exp=%h", grt, rb(3,2)); end
    n_cmp++; if (out_lck !== 5'b0) begin n_bad++; $display("FAIL lk_free got=%h exp=0", out_lck); end
    tick(); req = '0;
  endtask

  task automatic test_credits();
    do_reset();
    req = rb(0,0); req_vc = '0; req_tail = 5'b00001;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (grt !== rb(0,0)) begin n_bad++; $display("FAIL cr_g%0d got=%h exp=%h", k, grt, rb(0,0)); end
      tick();
    end
    #1;
    n_cmp++; if (grt !== '0)       begin n_bad++; $display("FAIL cr_stall got=%h exp=0", grt); end
    n_cmp++; if (vc_rdy[0] !== 1'b0) begin n_bad++; $display("FAIL cr_rdy0 got=%b exp=0", vc_rdy[0]); end
    credit_in = 10'b1; #1;
    n_cmp++; if (grt !== '0)       begin n_bad++; $display("FAIL cr_same got=%h exp=0", grt); end
    tick(); credit_in = '0; #1;
    n_cmp++; if (grt !== rb(0,0)) begin n_bad++; $display("FAIL cr_ret got=%h exp=%h", grt, rb(0,0)); end
    tick(); req = '0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    req = rb(0,1); req_vc = '0; req_tail = 5'b00001;
    tick(); tick();                 // count 4 -> 2
    credit_in = 10'b0000000100; #1;
    n_cmp++; if (grt !== rb(0,1)) begin n_bad++; $display("FAIL sc_g got=%h exp=%h", grt, rb(0,1)); end
    tick(); credit_in = '0; #1;    // count should still be 2
    n_cmp++; if (grt !== rb(0,1)) begin n_bad++; $display("FAIL sc_g2 got=%h exp=%h", grt, rb(0,1)); end
    tick(); #1;
    n_cmp++; if (grt !== rb(0,1)) begin n_bad++; $display("FAIL sc_g1 got=%h exp=%h", grt, rb(0,1)); end
    tick(); #1;
    n_cmp++; if (grt !== '0)      begin n_bad++; $display("FAIL sc_g0 got=%h exp=0", grt); end
    n_cmp++; if (vc_rdy[2] !== 1'b0) begin n_bad++; $display("FAIL sc_rdy got=%b exp=0", vc_rdy[2]); end
    req = '0;
  endtask

  task automatic test_overflow();
    do_reset(); #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ov_pre got=%b exp=0", err); end
    credit_in = 10'b0010000000;
    tick(); credit_in = '0; #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ov_set got=%b exp=1", err); end
    req = rb(2,3); req_vc = 5'b00100; req_tail = 5'b00100;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (grt !== rb(2,3) || grt_vc !== 5'b00100)
        begin n_bad++; $display("FAIL ov_g%0d got=%h/%h exp=%h/04", k, grt, grt_vc, rb(2,3)); end
      tick();
    end
    #1;
    n_cmp++; if (grt !== '0) begin n_bad++; $display("FAIL ov_cap got=%h exp=0", grt); end
    req = '0;
    repeat (3) tick();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ov_sticky got=%b exp=1", err); end
    rst_ = 1'b1; #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ov_clr got=%b exp=0", err); end
    tick(); rst_ = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = rb(2,3); req_vc = '0; req_tail = '0; #1;
    n_cmp++; if (grt !== rb(2,3)) begin n_bad++; $display("FAIL rm_head got=%h exp=%h", grt, rb(2,3)); end
    tick(); #1;
    n_cmp++; if (out_lck !== 5'b01000) begin n_bad++; $display("FAIL rm_lck got=%h exp=08", out_lck); end
    #1 rst_ = 1'b1; #1;
    n_cmp++; if (out_lck !== '0) begin n_bad++; $display("FAIL rm_lck0 got=%h exp=0", out_lck); end
    n_cmp++; if (grt !== '0)     begin n_bad++; $display("FAIL rm_grt0 got=%h exp=0", grt); end
    n_cmp++; if (vc_rdy !== 10'h3ff) begin n_bad++; $display("FAIL rm_rdy got=%h exp=3ff", vc_rdy); end
    tick(); rst_ = 1'b0;
    req = rb(2,3) | rb(0,3); req_tail = 5'b00001; #1;
    n_cmp++; if (grt !== rb(0,3)) begin n_bad++; $display("FAIL rm_new got=%h exp=%h", grt, rb(0,3)); end
    tick(); req = '0;
  endtask

  initial begin
    test_reset();
    test_rr();
    test_lock();
    test_credits();
    test_same_cycle();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
